// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core pipeline and the RV32M multiply/divide unit.
// The core drives the master side; the unit implements the slave side.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd;
  logic            flush;
  logic            busy;
  logic            done;
  logic            wr_en;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd, flush,
    input  busy, done, wr_en, rd_out, result
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd, flush,
    output busy, done, wr_en, rd_out, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with the sign fixed up when the result is written back.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2:0]      OP_MUL    = 3'b000;
  localparam logic [2:0]      OP_MULHU  = 3'b011;

  state_t            state;
  logic [2:0]        op;
  logic [4:0]        rd_lat;
  logic              neg_res;
  logic [5:0]        count;
  logic [XLEN-1:0]   mag_op;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;
  logic              done_q;
  logic              wr_en_q;
  logic [4:0]        rd_out_q;
  logic [XLEN-1:0]   result_q;

  logic              a_signed;
  logic              b_signed;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              start_neg;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic [XLEN-1:0]   special_res;

  // Decode of the live request; only consumed on the edge that accepts it.
  always_comb begin
    a_signed    = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3 != OP_MULHU);
    b_signed    = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    neg_a       = a_signed & bus.rs1_data[XLEN-1];
    neg_b       = b_signed & bus.rs2_data[XLEN-1];
    mag_a       = neg_a ? -bus.rs1_data : bus.rs1_data;
    mag_b       = neg_b ? -bus.rs2_data : bus.rs2_data;
    start_neg   = (bus.funct3[2] && bus.funct3[1]) ? neg_a : (neg_a ^ neg_b);
    div_zero    = bus.funct3[2] && (bus.rs2_data == '0);
    div_ovf     = bus.funct3[2] && !bus.funct3[0] &&
                  (bus.rs1_data == MIN_INT) && (bus.rs2_data == '1);
    special     = div_zero | div_ovf;
    if (div_zero) special_res = bus.funct3[1] ? bus.rs1_data : '1;
    else          special_res = bus.funct3[1] ? '0 : MIN_INT;
  end

  logic [XLEN:0]     sum_hi;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN:0]     partial;
  logic              q_bit;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_next;
  logic [XLEN-1:0]   quo_fin;
  logic [XLEN-1:0]   rem_fin;
  logic [XLEN-1:0]   final_res;

  // Multiply keeps the multiplier in acc's low half and shifts the product in from the top;
  // divide shifts the dividend out of acc's low half while quotient bits shift in behind it.
  always_comb begin
    sum_hi   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mag_op};
    mul_next = acc[0] ? {sum_hi, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    partial  = {rem, acc[XLEN-1]};
    q_bit    = (partial >= {1'b0, mag_op});
    rem_next = q_bit ? (partial[XLEN-1:0] - mag_op) : partial[XLEN-1:0];
    quo_next = {acc[XLEN-2:0], q_bit};
    prod_fin = neg_res ? -mul_next : mul_next;
    quo_fin  = neg_res ? -quo_next : quo_next;
    rem_fin  = neg_res ? -rem_next : rem_next;
    if (op[2])              final_res = op[1] ? rem_fin : quo_fin;
    else if (op == OP_MUL)  final_res = prod_fin[XLEN-1:0];
    else                    final_res = prod_fin[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op       <= '0;
      rd_lat   <= '0;
      neg_res  <= 1'b0;
      count    <= '0;
      mag_op   <= '0;
      acc      <= '0;
      rem      <= '0;
      done_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_out_q <= '0;
      result_q <= '0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            if (special) begin
              state    <= DONE;
              result_q <= special_res;
              rd_out_q <= bus.rd;
              done_q   <= 1'b1;
              wr_en_q  <= (bus.rd != '0);
            end else begin
              state   <= CALC;
              op      <= bus.funct3;
              rd_lat  <= bus.rd;
              neg_res <= start_neg;
              count   <= '0;
              mag_op  <= bus.funct3[2] ? mag_b : mag_a;
              acc     <= {{XLEN{1'b0}}, (bus.funct3[2] ? mag_a : mag_b)};
              rem     <= '0;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            acc   <= op[2] ? {acc[2*XLEN-1:XLEN], quo_next} : mul_next;
            rem   <= rem_next;
            count <= count + 6'd1;
            if (count == 6'd31) begin
              state    <= DONE;
              result_q <= final_res;
              rd_out_q <= rd_lat;
              done_q   <= 1'b1;
              wr_en_q  <= (rd_lat != '0);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.wr_en  = wr_en_q;
  assign bus.rd_out = rd_out_q;
  assign bus.result = result_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the RISC-V core. It takes the two source operands read from the register file, computes one of the eight M-extension operations over multiple cycles, and produces a destination index, a result word and a write strobe. These drive the register file's write port: `result` goes to Write_Data, `rd_out` to Write_Register and `wr_en` to Write_Enable. The unit holds one operation at a time; the core stalls on `busy`.

## Interface

Parameters
- XLEN, 32, operand and result width. Only 32 is supported.

Ports
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset; synchronous, active-high.
- start, input, 1, request a new operation; sampled only in IDLE.
- funct3, input, 3, operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data, input, 32, operand A (multiplicand / dividend).
- rs2_data, input, 32, operand B (multiplier / divisor).
- rd, input, 5, destination register index.
- flush, input, 1, abort any in-flight operation.
- busy, output, 1, high whenever state is not IDLE.
- done, output, 1, one-cycle completion pulse.
- wr_en, output, 1, register file write enable; equals done AND (rd_out != 0).
- rd_out, output, 5, latched destination index.
- result, output, 32, final result; valid when done is high and held afterwards.

## Operation

- FSM states: IDLE, CALC, DONE.
- IDLE -> CALC: start=1 and flush=0. Entry actions:
  - latch funct3 and rd;
  - latch operand magnitudes (absolute value for each signed operand);
  - latch the result sign;
  - clear the 6-bit iteration counter.
- IDLE -> DONE (fast path, skips CALC): start=1 with a divide special case.
  - DIV/DIVU with rs2=0: quotient 0xFFFFFFFF.
  - REM/REMU with rs2=0: remainder = rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Operand signedness:
  - MUL, MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV, REM: both signed.
- Result sign:
  - Products: XOR of the signed-operand signs.
  - Quotient: sign(rs1) XOR sign(rs2).
  - Remainder: sign(rs1).
- CALC, multiply: shift-add, one multiplier bit per cycle, 64-bit unsigned accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, 33-bit partial remainder.
- CALC -> DONE when the counter reaches 31, i.e. after exactly 32 CALC cycles.
- DONE: apply two's-complement negation if the result sign is set, then select:
  - MUL: low 32 bits of the product;
  - MULH/MULHSU/MULHU: high 32 bits of the product;
  - DIV/DIVU: quotient;
  - REM/REMU: remainder.
- DONE: result and rd_out register, done=1 for exactly one cycle, then unconditionally -> IDLE.
- start while busy is ignored; inputs are not queued.
- flush in any state returns to IDLE on the next edge with no done or wr_en.
  - flush wins over a simultaneous start.
  - flush during DONE has no effect: the pulse already occurs that cycle.
- rd=0: the operation runs and done pulses, but wr_en stays 0 (x0 protection; the register file does not guard x0).

## Timing

- Reset values: state IDLE, busy 0, done 0, wr_en 0, rd_out 0, result 0, counter 0.
- Reset mid-operation aborts the operation; no done pulse afterwards.
- Normal latency: start high in cycle 0.
  - busy high in cycles 1-33.
  - done/wr_en high in cycle 33.
  - busy low in cycle 34, when a new start is accepted.
- Special-case latency: done in cycle 1; busy high in cycle 1 only.
- Back-to-back throughput: one operation per 34 cycles (normal) or 2 cycles (special case).
- Inputs are sampled only on the accepting edge; rs1_data/rs2_data/rd/funct3 may change while busy.
- done, wr_en and rd_out are registered outputs. result is registered and changes only on the edge entering DONE or on reset.

## Test plan

- MUL, rs1=0x00000007, rs2=0xFFFFFFFD, rd=5 -> cycle 33: done=1, wr_en=1, rd_out=5, result=0xFFFFFFEB. Cycle 34: done=0, busy=0.
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
  - All complete in cycle 33.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - Each has done in cycle 1.
- Op with rd=0 -> done pulses, wr_en stays 0.
  - Second start issued in cycle 5 of a MUL -> ignored; exactly one done, carrying the first op's result.
- flush in cycle 10 -> busy=0 in cycle 11 and no done ever.
  - New start in cycle 11 -> done in cycle 44.
  - Repeat with rst in place of flush -> all outputs 0 in cycle 11.
